// File: rtl/soc_irq_pkg.sv
`default_nettype none
//============================================================================
// Module      : soc_irq_pkg
// Description : Shared types and parameter legality helper for the
//               interrupt conditioner.
// Revision    : 1.0 - initial release
//============================================================================
package soc_irq_pkg;

    // Per-line pulse sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } irq_cond_state_e;

    // Both the filter depth and the pulse width must be at least one cycle
    function automatic bit irq_cond_params_ok(input int filter_cycles,
                                              input int pulse_cycles);
        return (filter_cycles >= 1) && (pulse_cycles >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_cond_line.sv
`default_nettype none
//============================================================================
// Module      : irq_cond_line
// Description : One interrupt line: input sample with polarity fix,
//               glitch filter, fixed-width pulse generator with a one-deep
//               pending slot and a sticky drop flag.
// Revision    : 1.0 - initial release
//============================================================================
module irq_cond_line
    import soc_irq_pkg::*;
#(
    parameter logic ACTIVE_LOW    = 1'b0,
    parameter int   FILTER_CYCLES = 3,
    parameter int   PULSE_CYCLES  = 2
) (
    input  logic aclk,
    input  logic areset,
    input  logic src_i,
    input  logic drop_clr_i,
    output logic irq_o,
    output logic level_o,
    output logic drop_o
);

    localparam int c_CW = $clog2(FILTER_CYCLES) + 1;
    localparam int c_PW = $clog2(PULSE_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(FILTER_CYCLES - 1);
    localparam logic [c_PW-1:0] c_PCNT_LAST = c_PW'(PULSE_CYCLES - 1);

    logic            r_s;
    logic            r_filt;
    logic [c_CW-1:0] r_cnt;
    logic [c_PW-1:0] r_pcnt;
    logic            r_pend;
    logic            r_drop;
    irq_cond_state_e r_state;

    logic w_rise;
    logic w_drop_evt;

    // Filtered level is about to flip from 0 to 1 on this edge
    assign w_rise     = r_s && !r_filt && (r_cnt == c_CNT_LAST);
    // An edge arriving mid-pulse with the pending slot already taken is lost
    assign w_drop_evt = w_rise && r_pend && (r_state == PULSE);

    // Sample the source and accept a level change only after it has held steady
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s    <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s <= src_i ^ ACTIVE_LOW;
            if (r_s == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Pulse sequencer: fixed-width pulse, one mandatory low cycle, one buffered edge
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
            r_pend  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= (r_drop & ~drop_clr_i) | w_drop_evt;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PULSE;
                        r_pcnt  <= '0;
                    end
                end
                PULSE: begin
                    r_pcnt <= r_pcnt + 1'b1;
                    if (r_pcnt == c_PCNT_LAST) begin
                        r_state <= GAP;
                    end
                    if (w_rise && !r_pend) begin
                        r_pend <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_pend || w_rise) begin
                        r_state <= PULSE;
                        r_pcnt  <= '0;
                        // A buffered edge is consumed here; a coincident new
                        // edge takes its place, otherwise the slot empties
                        r_pend  <= r_pend && w_rise;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign irq_o   = (r_state == PULSE);
    assign level_o = r_filt;
    assign drop_o  = r_drop;

endmodule
`default_nettype wire

// File: rtl/irq_conditioner.sv
`default_nettype none
//============================================================================
// Module      : irq_conditioner
// Description : Conditions N_IRQ raw interrupt sources into clean,
//               spaced, fixed-width rising-edge pulses for the interrupt
//               controller.
// Revision    : 1.0 - initial release
//============================================================================
module irq_conditioner
    import soc_irq_pkg::*;
#(
    parameter int               N_IRQ         = 8,
    parameter logic [N_IRQ-1:0] ACTIVE_LOW    = '0,
    parameter int               FILTER_CYCLES = 3,
    parameter int               PULSE_CYCLES  = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [N_IRQ-1:0] src_i,
    input  logic [N_IRQ-1:0] drop_clr_i,
    output logic [N_IRQ-1:0] irq_o,
    output logic [N_IRQ-1:0] level_o,
    output logic [N_IRQ-1:0] drop_o
);

    // Refuse to elaborate with a zero-length filter or pulse
    if (!irq_cond_params_ok(FILTER_CYCLES, PULSE_CYCLES)) begin : g_param_err
        $error("irq_conditioner: FILTER_CYCLES and PULSE_CYCLES must both be >= 1");
    end

    // One independent conditioner per interrupt line
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
        irq_cond_line #(
            .ACTIVE_LOW    (ACTIVE_LOW[gi]),
            .FILTER_CYCLES (FILTER_CYCLES),
            .PULSE_CYCLES  (PULSE_CYCLES)
        ) u_line (
            .aclk       (aclk),
            .areset     (areset),
            .src_i      (src_i[gi]),
            .drop_clr_i (drop_clr_i[gi]),
            .irq_o      (irq_o[gi]),
            .level_o    (level_o[gi]),
            .drop_o     (drop_o[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_conditioner.sv
`default_nettype none
//============================================================================
// Module      : tb_irq_conditioner
// Description : Self-checking bench for irq_conditioner. Three instances
//               (default, active-low line 2, fast filter / long pulse)
//               share stimulus; a pulse-schedule model predicts every output.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
module tb_irq_conditioner;

    logic       clk = 1'b0;
    logic       areset;
    logic [7:0] src;
    logic [7:0] clr;

    logic [7:0] irq0, lvl0, drp0;
    logic [7:0] irq1, lvl1, drp1;
    logic [7:0] irq2, lvl2, drp2;

    int n_cmp = 0;
    int n_bad = 0;
    int n_prints = 0;

    always #5 clk = ~clk;

    irq_conditioner u0 (
        .aclk(clk), .areset(areset), .src_i(src), .drop_clr_i(clr),
        .irq_o(irq0), .level_o(lvl0), .drop_o(drp0)
    );
    irq_conditioner #(.ACTIVE_LOW(8'h04)) u1 (
        .aclk(clk), .areset(areset), .src_i(src), .drop_clr_i(clr),
        .irq_o(irq1), .level_o(lvl1), .drop_o(drp1)
    );
    irq_conditioner #(.FILTER_CYCLES(1), .PULSE_CYCLES(4)) u2 (
        .aclk(clk), .areset(areset), .src_i(src), .drop_clr_i(clr),
        .irq_o(irq2), .level_o(lvl2), .drop_o(drp2)
    );

    // ---------------- behavioural model ----------------
    // Filter: the level flips once the last FILTER_CYCLES samples all disagree
    // with it. Pulses: a schedule of start cycles; a new pulse may begin only
    // once the previous pulse plus its one low cycle has passed.
    int         cyc = 0;
    bit         mvalid = 1'b0;
    bit         m_s    [3][8];
    bit         m_filt [3][8];
    logic [7:0] m_hist [3][8];
    int         m_start[3][8];
    int         m_nfree[3][8];
    bit         m_pend [3][8];
    bit         m_drop [3][8];

    function automatic int fcv(input int k);
        return (k == 2) ? 1 : 3;
    endfunction
    function automatic int pcv(input int k);
        return (k == 2) ? 4 : 2;
    endfunction
    function automatic logic [7:0] alv(input int k);
        return (k == 1) ? 8'h04 : 8'h00;
    endfunction

    task automatic mdl_edge(input int k, input int i);
        int         fc, pc;
        logic [7:0] mask, al;
        bit         rise, started, lost;
        fc   = fcv(k);
        pc   = pcv(k);
        al   = alv(k);
        mask = 8'((1 << fc) - 1);
        if (areset) begin
            m_s[k][i]     = 1'b0;
            m_filt[k][i]  = 1'b0;
            m_hist[k][i]  = 8'h00;
            m_start[k][i] = -1000;
            m_nfree[k][i] = 0;
            m_pend[k][i]  = 1'b0;
            m_drop[k][i]  = 1'b0;
        end else begin
            m_hist[k][i] = {m_hist[k][i][6:0], m_s[k][i]};
            rise = 1'b0;
            if ((m_hist[k][i] & mask) == (m_filt[k][i] ? 8'h00 : mask)) begin
                m_filt[k][i] = !m_filt[k][i];
                rise = m_filt[k][i];
            end
            started = 1'b0;
            lost    = 1'b0;
            if (m_pend[k][i] && cyc >= m_nfree[k][i]) begin
                m_start[k][i] = cyc;
                m_nfree[k][i] = cyc + pc + 1;
                m_pend[k][i]  = 1'b0;
                started = 1'b1;
            end
            if (rise) begin
                if (!started && cyc >= m_nfree[k][i]) begin
                    m_start[k][i] = cyc;
                    m_nfree[k][i] = cyc + pc + 1;
                end else if (!m_pend[k][i]) begin
                    m_pend[k][i] = 1'b1;
                end else begin
                    lost = 1'b1;
                end
            end
            m_drop[k][i] = (m_drop[k][i] && !clr[i]) || lost;
            m_s[k][i]    = src[i] ^ al[i];
        end
    endtask

    function automatic logic [23:0] mdl_vec(input int k);
        logic [7:0] a, b, d;
        int         pc;
        a  = 8'h00;
        b  = 8'h00;
        d  = 8'h00;
        pc = pcv(k);
        for (int i = 0; i < 8; i++) begin
            a[i] = (cyc >= m_start[k][i]) && (cyc < m_start[k][i] + pc);
            b[i] = m_filt[k][i];
            d[i] = m_drop[k][i];
        end
        return {d, b, a};
    endfunction

    function automatic logic [23:0] dut_vec(input int k);
        case (k)
            0:       return {drp0, lvl0, irq0};
            1:       return {drp1, lvl1, irq1};
            default: return {drp2, lvl2, irq2};
        endcase
    endfunction

    // Model advances on every active edge using the inputs seen at that edge
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++)
                mdl_edge(k, i);
        if (areset) mvalid = 1'b1;
    end

    // Compare every instance against the model mid-cycle
    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            for (int k = 0; k < 3; k++) begin
                logic [23:0] act, exp;
                act = dut_vec(k);
                exp = mdl_vec(k);
                n_cmp++;
                if (act !== exp) begin
                    n_bad++;
                    if (n_prints < 20) begin
                        n_prints++;
                        $display("FAIL model_u%0d cyc %0d: got drop/level/irq=%h required %h",
                                 k, cyc, act, exp);
                    end
                end
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    logic [15:0] v_a, v_b, v_c;
    int          rate;

    initial begin
        areset = 1'b1;
        src    = 8'h04;
        clr    = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_u0", {8'h00, drp0, lvl0, irq0}, 32'h0);
        chk("reset_u1", {8'h00, drp1, lvl1, irq1}, 32'h0);
        chk("reset_u2", {8'h00, drp2, lvl2, irq2}, 32'h0);
        areset = 1'b0;

        // Active-low source idling high produces nothing
        v_a = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            v_a[0] = v_a[0] | irq1[2] | lvl1[2];
        end
        chk("al_idle_quiet", 32'(v_a), 32'h0);

        // Basic pulse on line 0 and active-low assertion on line 2
        v_a = '0; v_b = '0; v_c = '0;
        for (int c = 0; c < 14; c++) begin
            src[0] = 1'b1;
            src[2] = 1'b0;
            @(negedge clk);
            v_a[c] = irq0[0];
            v_b[c] = lvl0[0];
            v_c[c] = irq1[2];
        end
        chk("basic_irq0", 32'(v_a[13:0]), 32'h0018);
        chk("basic_level0", 32'(v_b[13:0]), 32'h3FF8);
        chk("al_irq2", 32'(v_c[13:0]), 32'h0018);

        // 2-cycle glitch on line 1, 2-cycle dip on held line 0
        v_a = '0; v_b = '0; v_c = 16'hFFFF;
        for (int c = 0; c < 12; c++) begin
            src[1] = (c < 2);
            src[0] = !(c < 2);
            @(negedge clk);
            v_a[0] = v_a[0] | irq0[1] | lvl0[1];
            v_b[0] = v_b[0] | irq0[0];
            v_c[0] = v_c[0] & lvl0[0];
        end
        chk("glitch_line1", 32'(v_a[0]), 32'h0);
        chk("dip_no_pulse", 32'(v_b[0]), 32'h0);
        chk("dip_level_held", 32'(v_c[0]), 32'h1);
        src = 8'h00;
        repeat (12) @(negedge clk);

        // Coalesce/drop on line 3 and back-to-back via GAP on line 4 (u2)
        v_a = '0; v_b = '0;
        for (int c = 0; c < 14; c++) begin
            src[3] = (c < 6) && (c % 2 == 0);
            src[4] = (c != 4);
            @(negedge clk);
            v_a[c] = irq2[3];
            v_b[c] = irq2[4];
        end
        chk("coalesce_irq3", 32'(v_a[13:0]), 32'h03DE);
        chk("gap_b2b_irq4", 32'(v_b[13:0]), 32'h03DE);
        chk("drop3_set", 32'(drp2[3]), 32'h1);
        chk("drop4_clear", 32'(drp2[4]), 32'h0);
        src = 8'h00;
        repeat (5) @(negedge clk);
        chk("drop3_sticky", 32'(drp2[3]), 32'h1);
        clr[3] = 1'b1;
        @(negedge clk);
        clr[3] = 1'b0;
        chk("drop3_cleared", 32'(drp2[3]), 32'h0);
        repeat (6) @(negedge clk);

        // Clear coincident with a new drop: set wins
        for (int c = 0; c < 8; c++) begin
            src[3] = (c < 6) && (c % 2 == 0);
            clr[3] = (c == 5);
            @(negedge clk);
        end
        clr = 8'h00;
        chk("drop3_set_wins", 32'(drp2[3]), 32'h1);
        src = 8'h00;
        repeat (12) @(negedge clk);

        // Reset mid-pulse on u2 line 0 with an edge pending
        for (int c = 0; c < 4; c++) begin
            src[0] = (c != 1);
            @(negedge clk);
        end
        chk("pre_reset_irq_u2", 32'(irq2[0]), 32'h1);
        areset = 1'b1;
        @(negedge clk);
        chk("midrst_u0", {8'h00, drp0, lvl0, irq0}, 32'h0);
        chk("midrst_u2", {8'h00, drp2, lvl2, irq2}, 32'h0);
        areset = 1'b0;
        v_a = '0; v_b = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            v_a[c] = irq0[0];
            v_b[c] = irq2[0];
        end
        chk("post_rst_irq_u0", 32'(v_a), 32'h0018);
        chk("post_rst_irq_u2", 32'(v_b), 32'h001E);
        src = 8'h00;
        repeat (10) @(negedge clk);

        // Randomised traffic checked by the model
        rate = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(2))
                    0:       rate = 2;
                    1:       rate = 4;
                    default: rate = 12;
                endcase
            end
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(rate - 1) == 0) src[i] = ~src[i];
                clr[i] = ($urandom_range(7) == 0);
            end
            areset = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        areset = 1'b0;
        clr    = 8'h00;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
